// File: rtl/osc_pkg.sv
// Shared types and constants for the oscillator-bank phase scheduler.
package osc_pkg;

  localparam int unsigned NVOICE_MAX = 4;
  localparam int unsigned PHASE_W    = 32;
  localparam int unsigned VIDX_W     = $clog2(NVOICE_MAX);
  localparam int unsigned WAVE_W     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] fcw;
    logic [WAVE_W-1:0]  wave;
    logic               sync;
  } voice_cfg_t;

endpackage

// File: rtl/osc_sched_sample_divider.sv
// Free-running sample-frame divider; tick is high on the last cycle of each frame.
module sample_divider #(
  parameter int unsigned SAMPLE_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);

  // tick is registered from the next count so it lines up with cnt == SAMPLE_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == CNT_MAX);
    end
  end

endmodule

// File: rtl/osc_sched.sv
// Round-robin phase-accumulator scheduler sharing one adder across NVOICE voices.
// Optional hard sync to voice 0 wrap is enabled by defining OSC_SCHED_SYNC_EN.
module osc_sched
  import osc_pkg::*;
#(
  parameter int unsigned NVOICE     = 3,
  parameter int unsigned SAMPLE_DIV = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [VIDX_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0]  cfg_fcw,
  input  logic [WAVE_W-1:0]   cfg_wave,
`ifdef OSC_SCHED_SYNC_EN
  input  logic                cfg_sync,
`endif
  output logic [PHASE_W-1:0]  phase,
  output logic [WAVE_W-1:0]   wave,
  output logic [VIDX_W-1:0]   voice,
  output logic                phase_valid,
  output logic                frame_done
);

  if (NVOICE < 2 || NVOICE > NVOICE_MAX) begin : g_bad_nvoice
    $error("osc_sched: NVOICE must be in 2..%0d", NVOICE_MAX);
  end
  if (SAMPLE_DIV < NVOICE + 2) begin : g_bad_div
    $error("osc_sched: SAMPLE_DIV must be >= NVOICE+2");
  end

  state_t             state;
  state_t             state_d;
  logic [VIDX_W-1:0]  idx;
  logic [VIDX_W-1:0]  idx_d;
  logic               tick;
  logic               last;
  logic               cfg_fire;
  voice_cfg_t         cfg_in;
  logic [PHASE_W-1:0] acc_next;
  logic [PHASE_W-1:0] acc [NVOICE];
  voice_cfg_t         cfg [NVOICE];

  sample_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign last      = (idx == VIDX_W'(NVOICE - 1));
  assign cfg_ready = (state == IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready && (32'(cfg_voice) < NVOICE);

`ifdef OSC_SCHED_SYNC_EN
  logic [PHASE_W:0] sum;
  logic             wrap0;

  assign sum    = {1'b0, acc[idx]} + {1'b0, cfg[idx].fcw};
  assign cfg_in = '{fcw: cfg_fcw, wave: cfg_wave, sync: cfg_sync};
  // later voices restart at fcw when voice 0 wrapped earlier in this frame
  assign acc_next = ((idx != '0) && wrap0 && cfg[idx].sync) ? cfg[idx].fcw
                                                            : sum[PHASE_W-1:0];
`else
  logic [PHASE_W-1:0] sum;

  assign sum      = acc[idx] + cfg[idx].fcw;
  assign cfg_in   = '{fcw: cfg_fcw, wave: cfg_wave, sync: 1'b0};
  assign acc_next = sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        idx_d = idx + VIDX_W'(1);
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
    endcase
  end

  // Accumulators, voice config and registered result port
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= '0;
      wave        <= '0;
      voice       <= '0;
      phase_valid <= 1'b0;
      frame_done  <= 1'b0;
      for (int i = 0; i < int'(NVOICE); i++) begin
        acc[i] <= '0;
        cfg[i] <= '0;
      end
`ifdef OSC_SCHED_SYNC_EN
      wrap0 <= 1'b0;
`endif
    end else begin
      phase_valid <= (state == RUN);
      frame_done  <= (state == RUN) && last;
      if (state == RUN) begin
        acc[idx] <= acc_next;
        phase    <= acc_next;
        wave     <= cfg[idx].wave;
        voice    <= idx;
`ifdef OSC_SCHED_SYNC_EN
        if (idx == '0) begin
          wrap0 <= sum[PHASE_W];
        end
`endif
      end
      if (cfg_fire) begin
        cfg[cfg_voice] <= cfg_in;
      end
    end
  end

endmodule

// File: tb/tb_osc_sched.sv
// Randomized bench for osc_sched against a frame-level reference model.
module tb_osc_sched;

  localparam int unsigned NV  = 3;
  localparam int unsigned DIV = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_voice;
  logic [31:0] cfg_fcw;
  logic [2:0]  cfg_wave;
  logic        cfg_sync;
  logic [31:0] phase;
  logic [2:0]  wave;
  logic [1:0]  voice;
  logic        phase_valid;
  logic        frame_done;

  always #5 clk = ~clk;

  osc_sched #(.NVOICE(NV), .SAMPLE_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_voice   (cfg_voice),
    .cfg_fcw     (cfg_fcw),
    .cfg_wave    (cfg_wave),
`ifdef OSC_SCHED_SYNC_EN
    .cfg_sync    (cfg_sync),
`endif
    .phase       (phase),
    .wave        (wave),
    .voice       (voice),
    .phase_valid (phase_valid),
    .frame_done  (frame_done)
  );

  typedef struct {
    int          cyc;
    logic [31:0] ph;
    logic [2:0]  wv;
    logic [1:0]  vc;
    logic        dn;
  } exp_t;

  int          checks;
  int          errors;
  int          c;
  int          stage;
  int          rnd;
  logic [31:0] m_acc  [NV];
  logic [31:0] m_fcw  [NV];
  logic [2:0]  m_wave [NV];
  logic        m_sync [NV];
  exp_t        q [$];
  logic [31:0] h_phase;
  logic [2:0]  h_wave;
  logic [1:0]  h_voice;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s stage=%0d c=%0d got %h want %h", name, stage, c, act, exp);
    end
  endtask

  function automatic bit ready_at(input int cy);
    return !(cy >= int'(DIV) && (cy % int'(DIV)) < int'(NV));
  endfunction

  task automatic model_reset();
    for (int v = 0; v < int'(NV); v++) begin
      m_acc[v] = '0; m_fcw[v] = '0; m_wave[v] = '0; m_sync[v] = 1'b0;
    end
    q.delete();
    h_phase = '0; h_wave = '0; h_voice = '0;
    c = 0;
  endtask

  // One whole frame computed at the tick; results appear at T+2+v
  task automatic run_frame(input int t);
    logic [32:0] s;
    logic        wrapped;
    exp_t        e;
    wrapped = 1'b0;
    for (int v = 0; v < int'(NV); v++) begin
      s = {1'b0, m_acc[v]} + {1'b0, m_fcw[v]};
      if (v == 0) wrapped = s[32];
`ifdef OSC_SCHED_SYNC_EN
      if (v != 0 && wrapped && m_sync[v]) s = {1'b0, m_fcw[v]};
`endif
      m_acc[v] = s[31:0];
      e.cyc = t + 2 + v; e.ph = s[31:0]; e.wv = m_wave[v];
      e.vc = 2'(v); e.dn = (v == int'(NV) - 1);
      q.push_back(e);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (cfg_valid && ready_at(c) && int'(cfg_voice) < int'(NV)) begin
      m_fcw[cfg_voice]  = cfg_fcw;
      m_wave[cfg_voice] = cfg_wave;
      m_sync[cfg_voice] = cfg_sync;
    end
    if ((c % int'(DIV)) == int'(DIV) - 1) run_frame(c);
    c++;
  endtask

  task automatic compare_cycle();
    exp_t e;
    chk("cfg_ready", cfg_ready, 32'(ready_at(c)));
    if (q.size() > 0 && q[0].cyc == c) begin
      e = q.pop_front();
      h_phase = e.ph; h_wave = e.wv; h_voice = e.vc;
      chk("phase_valid", phase_valid, 1);
      chk("frame_done", frame_done, 32'(e.dn));
    end else begin
      chk("phase_valid", phase_valid, 0);
      chk("frame_done", frame_done, 0);
    end
    chk("phase", phase, h_phase);
    chk("wave", wave, 32'(h_wave));
    chk("voice", voice, 32'(h_voice));
  endtask

  // Hand-computed expectations that pin the model
  task automatic literal_checks();
    if (stage == 0) begin
      case (c)
        0:  begin chk("lit_rst_phase", phase, 0); chk("lit_rst_ready", cfg_ready, 1); end
        8:  chk("lit_no_early_valid", phase_valid, 0);
        9:  begin chk("lit_f1_v0", phase, 32'h4000_0000); chk("lit_f1_v0_valid", phase_valid, 1); end
        10: chk("lit_f1_v1", phase, 32'hFFFF_FFFF);
        11: begin chk("lit_f1_v2", phase, 32'h0000_0100); chk("lit_f1_done", frame_done, 1); end
        17: chk("lit_f2_v0", phase, 32'h8000_0000);
        18: chk("lit_f2_v1", phase, 32'hFFFF_FFFE);
        25: chk("lit_f3_v0", phase, 32'hC000_0000);
        33: chk("lit_f4_v0", phase, 32'h0000_0000);
        41: chk("lit_old_fcw", phase, 32'h4000_0000);
        42: chk("lit_stall_ready", cfg_ready, 0);
        43: chk("lit_fire_ready", cfg_ready, 1);
        49: chk("lit_new_fcw", phase, 32'h4000_0001);
        57: chk("lit_pre_reset", phase, 32'h4000_0002);
        default: ;
      endcase
    end else if (stage == 1) begin
      case (c)
        0:  begin chk("lit_rst2_phase", phase, 0); chk("lit_rst2_valid", phase_valid, 0); end
        9:  chk("lit_s_v0", phase, 32'h8000_0000);
`ifdef OSC_SCHED_SYNC_EN
        10: chk("lit_s_f1", phase, 32'h1000_0000);
        18: chk("lit_s_f2", phase, 32'h1000_0000);
        26: chk("lit_s_f3", phase, 32'h2000_0000);
        34: chk("lit_s_f4", phase, 32'h1000_0000);
`else
        10: chk("lit_s_f1", phase, 32'h1000_0000);
        18: chk("lit_s_f2", phase, 32'h2000_0000);
        26: chk("lit_s_f3", phase, 32'h3000_0000);
        34: chk("lit_s_f4", phase, 32'h4000_0000);
`endif
        default: ;
      endcase
    end
  endtask

  task automatic wr(input logic [1:0] v, input logic [31:0] f, input logic [2:0] w, input logic s);
    cfg_valid = 1'b1; cfg_voice = v; cfg_fcw = f; cfg_wave = w; cfg_sync = s;
  endtask

  task automatic drive();
    int r;
    reset = 1'b0; cfg_valid = 1'b0;
    if (stage == 0) begin
      if (c == 0) wr(2'd0, 32'h4000_0000, 3'd1, 1'b0);
      if (c == 1) wr(2'd1, 32'hFFFF_FFFF, 3'd2, 1'b0);
      if (c == 7) wr(2'd2, 32'h0000_0100, 3'd3, 1'b0);
      if (c >= 40 && c <= 43) wr(2'd0, 32'h0000_0001, 3'd5, 1'b0);
      if (c == 57) begin reset = 1'b1; stage = 1; end
    end else if (stage == 1) begin
      if (c == 0) wr(2'd0, 32'h8000_0000, 3'd4, 1'b1);
      if (c == 1) wr(2'd1, 32'h1000_0000, 3'd6, 1'b1);
      if (c == 40) begin stage = 2; rnd = 0; end
    end else begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        wr(2'($urandom_range(0, 3)),
           (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      rnd++;
      if (rnd == 3000) stage = 3;
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_voice = '0; cfg_fcw = '0; cfg_wave = '0; cfg_sync = 1'b0;
    checks = 0; errors = 0; stage = 0; rnd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    while (stage < 3) begin
      @(negedge clk);
      compare_cycle();
      literal_checks();
      drive();
      model_edge();
    end
    @(negedge clk);
    compare_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
